// File: rtl/instr_encoder_loader_pkg.sv
// Shared MIPS definitions: opcode set, instruction field layout, loader FSM states.
// Opcode membership helpers are used by the packer to pick the word format and flag illegal records.
package mips_pkg;

    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;
    localparam int WORD_W   = 32;

    localparam int OPC_LSB  = 26;
    localparam int DEST_LSB = 21;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_LSB = 11;
    localparam int IMM_LSB  = 0;

    // Register-format opcodes
    localparam logic [OPC_W-1:0] OP_R00 = 6'd0;
    localparam logic [OPC_W-1:0] OP_R01 = 6'd1;
    localparam logic [OPC_W-1:0] OP_R03 = 6'd3;
    localparam logic [OPC_W-1:0] OP_R05 = 6'd5;
    localparam logic [OPC_W-1:0] OP_R06 = 6'd6;
    localparam logic [OPC_W-1:0] OP_R07 = 6'd7;
    localparam logic [OPC_W-1:0] OP_R08 = 6'd8;
    localparam logic [OPC_W-1:0] OP_R09 = 6'd9;
    localparam logic [OPC_W-1:0] OP_R10 = 6'd10;
    localparam logic [OPC_W-1:0] OP_R11 = 6'd11;
    localparam logic [OPC_W-1:0] OP_R12 = 6'd12;

    // Immediate-format opcodes
    localparam logic [OPC_W-1:0] OP_I32 = 6'd32;
    localparam logic [OPC_W-1:0] OP_I33 = 6'd33;
    localparam logic [OPC_W-1:0] OP_I36 = 6'd36;
    localparam logic [OPC_W-1:0] OP_I37 = 6'd37;
    localparam logic [OPC_W-1:0] OP_I40 = 6'd40;
    localparam logic [OPC_W-1:0] OP_I41 = 6'd41;
    localparam logic [OPC_W-1:0] OP_I42 = 6'd42;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    function automatic logic is_imm_op(input logic [OPC_W-1:0] op);
        logic r;
        case (op)
            OP_I32, OP_I33, OP_I36, OP_I37,
            OP_I40, OP_I41, OP_I42:          r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        logic r;
        case (op)
            OP_R00, OP_R01, OP_R03, OP_R05, OP_R06, OP_R07,
            OP_R08, OP_R09, OP_R10, OP_R11, OP_R12:          r = 1'b1;
            default:                                         r = is_imm_op(op);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-record stream (valid/ready) and instruction-memory write port.
// Handshake: a record transfers on a rising edge where in_valid & in_ready; in_ready never depends on in_valid.
interface instr_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_dest;
    logic [4:0]  in_src1;
    logic [4:0]  in_src2;
    logic [15:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_opcode, in_dest, in_src1, in_src2, in_imm, in_last,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_opcode, in_dest, in_src1, in_src2, in_imm, in_last,
        output in_ready
    );
endinterface

interface imem_wr_if #(parameter int ADDR_W = 8);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_encoder_loader_packer.sv
// Combinational fields-to-word packing for the ID-stage decoder, plus the legal-opcode flag.
module instr_packer
    import mips_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [REG_W-1:0]  dest_i,
    input  logic [REG_W-1:0]  src1_i,
    input  logic [REG_W-1:0]  src2_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [WORD_W-1:0] word_o,
    output logic              legal_o
);

    always_comb begin
        word_o                     = '0;
        word_o[OPC_LSB  +: OPC_W]  = opcode_i;
        word_o[DEST_LSB +: REG_W]  = dest_i;
        word_o[SRC1_LSB +: REG_W]  = src1_i;
        // Register format leaves [10:0] zero; immediate format drops src2
        if (is_imm_op(opcode_i)) begin
            word_o[IMM_LSB +: IMM_W] = imm_i;
        end else begin
            word_o[SRC2_LSB +: REG_W] = src2_i;
        end
        legal_o = is_legal_op(opcode_i);
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder / program loader feeding instruction memory and holding the CPU.
// Optional XOR checksum of written words is built only when PROG_CHECKSUM_EN is defined.
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    instr_stream_if.slave         in_if,
    imem_wr_if.master             mem_if,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  illegal,
    output logic                  full,
    output logic [ADDR_W:0]       count,
    output logic [31:0]           checksum,
    output loader_state_e         dbg_state_o
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   ONE       = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              illegal_q, illegal_d;
    logic              full_q, full_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              in_ready;
    logic              accept;
    logic              sess_start;
    logic [31:0]       packed_word;
    logic              packed_legal;

    instr_packer u_packer (
        .opcode_i (in_if.in_opcode),
        .dest_i   (in_if.in_dest),
        .src1_i   (in_if.in_src1),
        .src2_i   (in_if.in_src2),
        .imm_i    (in_if.in_imm),
        .word_o   (packed_word),
        .legal_o  (packed_legal)
    );

    assign in_ready   = (state_q == ST_LOAD) && !full_q;
    assign accept     = in_if.in_valid && in_ready;
    assign sess_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        full_d    = full_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (sess_start) begin
                    count_d   = '0;
                    illegal_d = 1'b0;
                    full_d    = 1'b0;
                    addr_d    = BASE;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (packed_legal) begin
                        // count moves with the write strobe; address uses the pre-increment count
                        we_d    = 1'b1;
                        addr_d  = BASE + count_q[ADDR_W-1:0];
                        wdata_d = packed_word;
                        count_d = count_q + ONE;
                        if (count_q == LAST_SLOT) begin
                            full_d  = 1'b1;
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                    if (in_if.in_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            illegal_q <= 1'b0;
            full_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= BASE;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            full_q    <= full_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (sess_start) begin
            chk_d = '0;
        end else if (we_q) begin
            chk_d = chk_q ^ wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign checksum = chk_q;
`else
    assign checksum = '0;
`endif

    assign in_if.in_ready   = in_ready;
    assign mem_if.mem_we    = we_q;
    assign mem_if.mem_addr  = addr_q;
    assign mem_if.mem_wdata = wdata_q;
    assign cpu_hold         = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign done             = (state_q == ST_DONE);
    assign illegal          = illegal_q;
    assign full             = full_q;
    assign count            = count_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: 256-word instance at base 0, 4-word instance at base 2.
module tb_instr_encoder_loader;
    import mips_pkg::*;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic cpu_hold_a, done_a, illegal_a, full_a;
    logic cpu_hold_b, done_b, illegal_b, full_b;
    logic [8:0]  count_a;
    logic [2:0]  count_b;
    logic [31:0] checksum_a, checksum_b;
    loader_state_e st_a, st_b;

    instr_stream_if sa ();
    instr_stream_if sb ();
    imem_wr_if #(.ADDR_W(8)) ma ();
    imem_wr_if #(.ADDR_W(2)) mb ();

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_if(sa), .mem_if(ma),
        .cpu_hold(cpu_hold_a), .done(done_a), .illegal(illegal_a), .full(full_a),
        .count(count_a), .checksum(checksum_a), .dbg_state_o(st_a)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_if(sb), .mem_if(mb),
        .cpu_hold(cpu_hold_b), .done(done_b), .illegal(illegal_b), .full(full_b),
        .count(count_b), .checksum(checksum_b), .dbg_state_o(st_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] exp_a[$];
    logic [39:0] exp_b[$];

    task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ck(input logic [31:0] v);
`ifdef PROG_CHECKSUM_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    always @(negedge clk) begin
        logic [39:0] e;
        if (ma.mem_we === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_extra_wr", 40'({ma.mem_addr, ma.mem_wdata}), 40'h0);
            end else begin
                e = exp_a.pop_front();
                check("a_wr", {ma.mem_addr, ma.mem_wdata}, e);
            end
        end
        if (mb.mem_we === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_extra_wr", 40'({mb.mem_addr, mb.mem_wdata}), 40'h0);
            end else begin
                e = exp_b.pop_front();
                check("b_wr", 40'({mb.mem_addr, mb.mem_wdata}), e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        sa.in_valid = 1'b0;
        sb.in_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [5:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [15:0] imm,
                        input logic last, input int budget, output bit acc);
        if (sel) begin
            sb.in_valid = 1'b1; sb.in_opcode = op; sb.in_dest = d;
            sb.in_src1 = s1; sb.in_src2 = s2; sb.in_imm = imm; sb.in_last = last;
        end else begin
            sa.in_valid = 1'b1; sa.in_opcode = op; sa.in_dest = d;
            sa.in_src1 = s1; sa.in_src2 = s2; sa.in_imm = imm; sa.in_last = last;
        end
        acc = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((!sel && sa.in_ready) || (sel && sb.in_ready)) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((!sel && done_a) || (sel && done_b)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit acc;
        bit ok;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sa.in_valid = 1'b0; sa.in_opcode = '0; sa.in_dest = '0; sa.in_src1 = '0;
        sa.in_src2 = '0; sa.in_imm = '0; sa.in_last = 1'b0;
        sb.in_valid = 1'b0; sb.in_opcode = '0; sb.in_dest = '0; sb.in_src1 = '0;
        sb.in_src2 = '0; sb.in_imm = '0; sb.in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready", 40'(sa.in_ready), 40'd0);
        check("rst_mem_we",   40'(ma.mem_we),   40'd0);
        check("rst_mem_addr", 40'(ma.mem_addr), 40'd0);
        check("rst_wdata",    40'(ma.mem_wdata), 40'd0);
        check("rst_hold",     40'(cpu_hold_a),  40'd0);
        check("rst_done",     40'(done_a),      40'd0);
        check("rst_illegal",  40'(illegal_a),   40'd0);
        check("rst_full",     40'(full_a),      40'd0);
        check("rst_count",    40'(count_a),     40'd0);
        check("rst_checksum", 40'(checksum_a),  40'd0);
        check("rst_state",    40'(st_a),        40'(ST_IDLE));
        check("rst_b_addr",   40'(mb.mem_addr), 40'd2);

        // Register op, single record; imm is garbage and must be ignored
        pulse_start(1'b0);
        check("t1_hold_rise", 40'(cpu_hold_a), 40'd1);
        check("t1_ready",     40'(sa.in_ready), 40'd1);
        exp_a.push_back(40'h00_04642800);
        send(1'b0, 6'd1, 5'd3, 5'd4, 5'd5, 16'hFFFF, 1'b1, 10, acc);
        idle_all();
        check("t1_acc",       40'(acc), 40'd1);
        check("t1_we_now",    40'(ma.mem_we), 40'd1);
        check("t1_count_now", 40'(count_a), 40'd1);
        check("t1_done_early", 40'(done_a), 40'd0);
        @(posedge clk);
        #1;
        check("t1_done",      40'(done_a), 40'd1);
        check("t1_hold_fall", 40'(cpu_hold_a), 40'd0);
        check("t1_we_off",    40'(ma.mem_we), 40'd0);
        check("t1_count",     40'(count_a), 40'd1);
        check("t1_checksum",  40'(checksum_a), 40'(exp_ck(32'h04642800)));

        // Immediate ops back to back; src2 is garbage and must be ignored
        pulse_start(1'b0);
        check("t2_count_clr", 40'(count_a), 40'd0);
        check("t2_ck_clr",    40'(checksum_a), 40'd0);
        exp_a.push_back(40'h00_804000FF);
        exp_a.push_back(40'h01_94220010);
        send(1'b0, 6'd32, 5'd2, 5'd0, 5'd31, 16'h00FF, 1'b0, 10, acc);
        check("t2_acc0",   40'(acc), 40'd1);
        check("t2_we0",    40'({ma.mem_we, ma.mem_addr}), 40'h100);
        send(1'b0, 6'd37, 5'd1, 5'd2, 5'd31, 16'h0010, 1'b1, 1, acc);
        idle_all();
        check("t2_acc1",   40'(acc), 40'd1);
        check("t2_we1",    40'({ma.mem_we, ma.mem_addr}), 40'h101);
        wait_done(1'b0, ok);
        check("t2_done",   40'(ok), 40'd1);
        check("t2_count",  40'(count_a), 40'd2);
        check("t2_checksum", 40'(checksum_a), 40'(exp_ck(32'h146200EF)));
        check("t2_illegal", 40'(illegal_a), 40'd0);

        // Illegal opcode between two legal records
        pulse_start(1'b0);
        exp_a.push_back(40'h00_04642800);
        exp_a.push_back(40'h01_804000FF);
        send(1'b0, 6'd1, 5'd3, 5'd4, 5'd5, 16'h0000, 1'b0, 10, acc);
        check("t3_acc0", 40'(acc), 40'd1);
        send(1'b0, 6'd2, 5'd7, 5'd7, 5'd7, 16'h1234, 1'b0, 10, acc);
        check("t3_acc_ill", 40'(acc), 40'd1);
        check("t3_illegal_now", 40'(illegal_a), 40'd1);
        check("t3_no_we",  40'(ma.mem_we), 40'd0);
        send(1'b0, 6'd32, 5'd2, 5'd0, 5'd0, 16'h00FF, 1'b1, 10, acc);
        idle_all();
        check("t3_acc2", 40'(acc), 40'd1);
        wait_done(1'b0, ok);
        check("t3_done",    40'(ok), 40'd1);
        check("t3_illegal", 40'(illegal_a), 40'd1);
        check("t3_count",   40'(count_a), 40'd2);
        check("t3_checksum", 40'(checksum_a), 40'(exp_ck(32'h842428FF)));

        // Full on the 4-word instance at base 2: addresses wrap 2,3,0,1
        pulse_start(1'b1);
        check("t4_hold", 40'(cpu_hold_b), 40'd1);
        exp_b.push_back(40'h02_A0201001);
        exp_b.push_back(40'h03_30403800);
        exp_b.push_back(40'h00_A0601003);
        exp_b.push_back(40'h01_A0801004);
        send(1'b1, 6'd40, 5'd1, 5'd0, 5'd0, 16'h1001, 1'b0, 10, acc);
        check("t4_acc0", 40'(acc), 40'd1);
        send(1'b1, 6'd12, 5'd2, 5'd0, 5'd7, 16'hBEEF, 1'b0, 10, acc);
        check("t4_acc1", 40'(acc), 40'd1);
        send(1'b1, 6'd40, 5'd3, 5'd0, 5'd0, 16'h1003, 1'b0, 10, acc);
        check("t4_acc2", 40'(acc), 40'd1);
        check("t4_full_early", 40'(full_b), 40'd0);
        send(1'b1, 6'd40, 5'd4, 5'd0, 5'd0, 16'h1004, 1'b0, 10, acc);
        check("t4_acc3",  40'(acc), 40'd1);
        check("t4_full",  40'(full_b), 40'd1);
        check("t4_ready", 40'(sb.in_ready), 40'd0);
        check("t4_count", 40'(count_b), 40'd4);
        send(1'b1, 6'd40, 5'd5, 5'd0, 5'd0, 16'h1005, 1'b0, 4, acc);
        check("t4_blocked5", 40'(acc), 40'd0);
        send(1'b1, 6'd40, 5'd6, 5'd0, 5'd0, 16'h1006, 1'b1, 4, acc);
        check("t4_blocked6", 40'(acc), 40'd0);
        idle_all();
        wait_done(1'b1, ok);
        check("t4_done",     40'(ok), 40'd1);
        check("t4_count_end", 40'(count_b), 40'd4);
        check("t4_checksum", 40'(checksum_b), 40'(exp_ck(32'h90802806)));

        // Reset mid-load: pending second write is abandoned
        pulse_start(1'b0);
        exp_a.push_back(40'h00_04642800);
        send(1'b0, 6'd1, 5'd3, 5'd4, 5'd5, 16'h0000, 1'b0, 10, acc);
        check("t5_acc0", 40'(acc), 40'd1);
        send(1'b0, 6'd32, 5'd2, 5'd0, 5'd0, 16'h00FF, 1'b0, 10, acc);
        check("t5_acc1", 40'(acc), 40'd1);
        idle_all();
        rst = 1'b1;
        #1;
        check("t5_we",    40'(ma.mem_we), 40'd0);
        check("t5_hold",  40'(cpu_hold_a), 40'd0);
        check("t5_count", 40'(count_a), 40'd0);
        check("t5_addr",  40'(ma.mem_addr), 40'd0);
        check("t5_state", 40'(st_a), 40'(ST_IDLE));
        check("t5_ck",    40'(checksum_a), 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse_start(1'b0);
        exp_a.push_back(40'h00_94220010);
        send(1'b0, 6'd37, 5'd1, 5'd2, 5'd0, 16'h0010, 1'b1, 10, acc);
        idle_all();
        check("t5_acc2", 40'(acc), 40'd1);
        wait_done(1'b0, ok);
        check("t5_done",  40'(ok), 40'd1);
        check("t5_count_new", 40'(count_a), 40'd1);

        repeat (2) @(posedge clk);
        #1;
        check("exp_a_empty", 40'(exp_a.size()), 40'd0);
        check("exp_b_empty", 40'(exp_b.size()), 40'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the pipelined MIPS core. It accepts decoded instruction fields over a valid/ready stream, packs them into 32-bit words in the format the ID-stage control unit decodes, and writes them sequentially into instruction memory. It holds the CPU while loading and sits between the host/test front end and the instruction-memory write port.

## Interface
- ADDR_W, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0: first word address written after `start`.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load session; sampled only in IDLE or DONE.
- in_valid  in  1  field record valid.
- in_ready  out  1  record accepted on a cycle where in_valid & in_ready.
- in_opcode  in  6  opcode.
- in_dest  in  5  destination register.
- in_src1  in  5  source register 1.
- in_src2  in  5  source register 2; ignored for immediate opcodes.
- in_imm  in  16  immediate; ignored for register opcodes.
- in_last  in  1  marks the final record of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- cpu_hold  out  1  stalls the core while loading.
- done  out  1  load session complete.
- illegal  out  1  sticky: at least one illegal opcode was dropped.
- full  out  1  memory capacity reached.
- count  out  ADDR_W+1  number of words written this session.
- checksum  out  32  XOR of all written words (see Configuration).

## Operation
- Encoding: word[31:26]=opcode, [25:21]=dest, [20:16]=src1. Immediate opcodes {32,33,36,37,40,41,42}: [15:0]=imm. All other opcodes: [15:11]=src2, [10:0]=0.
- Legal opcodes: {0,1,3,5,6,7,8,9,10,11,12,32,33,36,37,40,41,42}. Any other opcode is illegal. An illegal record is accepted (handshake completes) and dropped: no write, address not advanced, and `illegal` is set.
- FSM states:
  - IDLE: `start` clears count, illegal, full and checksum, loads the address with BASE_ADDR, and moves to LOAD.
  - LOAD: in_ready = ~full. Each accepted legal record is encoded and registered. An accepted record with in_last=1, legal or not, moves to FLUSH. Writing the slot that makes count reach 2^ADDR_W sets `full` and moves to FLUSH.
  - FLUSH: the final pending write completes, then the FSM moves to DONE.
  - DONE: done=1. `start` begins a new session exactly as from IDLE.
- `start` is ignored in LOAD and FLUSH.
- Address is BASE_ADDR+count, truncated to ADDR_W bits; it wraps modulo 2^ADDR_W when BASE_ADDR≠0.
- Records accepted after `full` is set are impossible, because in_ready=0.

## Timing
- Reset values: state IDLE; in_ready, mem_we, cpu_hold, done, illegal, full = 0; mem_addr = BASE_ADDR; mem_wdata, count, checksum = 0.
- Latency: a record accepted at edge N produces mem_we=1 with its address and data during the cycle after N, for exactly one cycle.
- Throughput: one record per cycle. in_ready is combinational from state and full only, never from in_valid.
- cpu_hold rises the cycle after `start` is sampled. It stays high through LOAD and FLUSH and falls on entry to DONE, in the same cycle that done rises.
- count increments in the same cycle mem_we is high.
- Reset mid-session: all outputs return to reset values immediately (asynchronously). A pending write is abandoned.

## Configuration
- PROG_CHECKSUM_EN defined: `checksum` accumulates the XOR of every mem_wdata written while mem_we=1, and is cleared on `start`.
- PROG_CHECKSUM_EN undefined: the accumulator is not built, and `checksum` is tied to 0. The port is present either way.

## Structure
- Shared package `mips_pkg`: opcode constants, the immediate-opcode set, the legal-opcode predicate function, instruction bit-field positions, and the loader FSM state enum.
- One sub-module, `instr_packer`: combinational fields-to-word packing plus the legal flag. The top level holds the FSM, address/count registers, write register and checksum.

## Test plan
- Register op: opcode 1, dest 3, src1 4, src2 5, last=1 after start with BASE_ADDR=0 -> one mem_we at addr 0 with data 0x04642800; done=1 two cycles after acceptance; count=1.
- Immediate ops back to back: (32, d2, s0, imm 0x00FF) then (37, d1, s2, imm 0x0010, last) -> writes 0x804000FF @0 and 0x94220010 @1 on consecutive cycles.
- Illegal drop: opcode 2 between two legal records -> illegal=1, only two writes at addresses 0 and 1, count=2.
- Full: ADDR_W=2, six records streamed -> four writes at addresses 0–3; full=1 and in_ready=0 after the fourth acceptance; done=1; the remaining records are never accepted.
- Reset mid-load: assert rst after two acceptances -> mem_we=0, cpu_hold=0, count=0 immediately; a new start writes from BASE_ADDR again.
- Checksum (PROG_CHECKSUM_EN defined): writes 0x04642800 and 0x804000FF -> checksum=0x842428FF. With the macro undefined, checksum=0.
